bist_response_analyzer: RTL and testbench
=========================================

Name: bist_response_analyzer

Overview:
Response side of the test-per-scan BIST loop. It consumes the controller's init/running/finish/mode strobes and compacts the scan-chain outputs into a MISR (multiple-input signature register). At finish it compares the signature and the compaction-cycle count against golden values and reports pass/fail. It sits between the scan-chain outputs and the top-level BIST status outputs, beside the controller.

Parameters:
MISR_WIDTH, 16, signature width in bits (≥ NUM_CHAINS, ≥ 2)
NUM_CHAINS, 4, number of scan-out bits compacted per cycle
POLY, 16'h1021, Galois feedback polynomial; bit i set means tap into bit i
SEED, 0, signature value loaded on init
GOLDEN_SIGNATURE, 16'h0000, expected final signature
EXPECTED_COUNT, 0, expected number of compaction cycles; 0 disables the count check
COUNT_W, 16, width of the compaction counter

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
init  input  1  controller init strobe; reseeds the analyzer
running  input  1  controller running level
finish  input  1  controller finish strobe; triggers the compare
mode  input  1  1 = scan shift (compact), 0 = capture/functional (no compaction)
scan_out  input  NUM_CHAINS  scan-chain serial outputs, one bit per chain
signature  output  MISR_WIDTH  current MISR contents
compact_count  output  COUNT_W  compaction cycles since last init, saturating
done  output  1  level; result valid
pass  output  1  level; valid only while done=1
proto_err  output  1  sticky until init or reset; finish arrived without a running phase

Behaviour:
- Reset: state IDLE; signature=0, compact_count=0, done=0, pass=0, proto_err=0. Reset takes priority over all inputs. Reset mid-operation aborts with no result.
- FSM states: IDLE, ARMED, COMPACT, DONE. All outputs are registered.
- init has priority over every other input in every state. It moves to ARMED, loads signature=SEED and compact_count=0, and clears done, pass and proto_err. An init during COMPACT restarts the run.
- IDLE: only init has an effect. running, finish and scan_out are ignored.
- ARMED:
  - running=1 → COMPACT. If mode=1 in that same cycle, the cycle is also compacted.
  - finish=1 (without running) → DONE with done=1, pass=0, proto_err=1.
- COMPACT:
  - Each cycle with running=1 and mode=1 and finish=0 is a compaction cycle.
  - Compaction update: signature ← {signature[W-2:0],0} XOR (signature[W-1] ? POLY : 0) XOR zero-extended scan_out. Chain i feeds bit i.
  - compact_count increments on each compaction cycle and saturates at all-ones.
  - mode=0 or running=0: signature and count hold.
  - finish=1 → DONE. scan_out is not compacted in the finish cycle.
  - pass = (signature == GOLDEN_SIGNATURE) AND (EXPECTED_COUNT==0 OR compact_count==EXPECTED_COUNT), evaluated on the registered values present at finish.
  - done and pass assert the cycle after finish is sampled (1-cycle latency).
- DONE:
  - done, pass, signature and compact_count hold until init or reset.
  - running, finish and scan_out are ignored.
- Simultaneous events:
  - init+finish: init wins.
  - init+running in IDLE or DONE: go to ARMED; running is honoured from the next cycle.
- X on scan_out during a compaction cycle propagates into signature; no internal masking without the optional feature.

Optional Feature:
BIST_RSP_XMASK_EN
- Defined: adds input scan_mask [NUM_CHAINS-1:0]. Any scan_out bit whose scan_mask bit is 1 is forced to 0 before compaction. Count behaviour is unchanged.
- Undefined: the port is absent and all bits are compacted.

Test Plan:
All scenarios use MISR_WIDTH=4, NUM_CHAINS=1, POLY=4'h3, SEED=0, GOLDEN=4'hB, EXPECTED_COUNT=4.
- Reset 3 cycles, then idle → signature=0, compact_count=0, done=0, pass=0, proto_err=0.
- Nominal run: init; running with mode=1 for 4 cycles, scan_out=1,0,1,1; then finish → signature steps 1,2,5,B; compact_count=4; next cycle done=1, pass=1.
- Count mismatch: same run plus a 5th compaction with scan_out=0 → signature=4'h5, compact_count=5, pass=0, done=1.
- mode=0 cycles interleaved among the 4 shift cycles → no change while mode=0; final signature=4'hB, pass=1.
- init then finish with no running → done=1, pass=0, proto_err=1. A following init clears all three.
- Mid-run disruption:
  - reset asserted after 2 compactions → all outputs 0 and state IDLE; a finish before init gives no done.
  - init after 2 compactions → signature=0, count=0, and a full 4-cycle rerun passes.

Source files
------------

// File: rtl/bist_response_analyzer.sv
// BIST response analyzer: compacts scan-chain outputs into a Galois MISR and checks the signature at finish.
// Optional X-masking input scan_mask is enabled by defining BIST_RSP_XMASK_EN.
module bist_response_analyzer #(
   parameter int unsigned            MISR_WIDTH       = 16,
   parameter int unsigned            NUM_CHAINS       = 4,
   parameter logic [MISR_WIDTH-1:0]  POLY             = 16'h1021,
   parameter logic [MISR_WIDTH-1:0]  SEED             = '0,
   parameter logic [MISR_WIDTH-1:0]  GOLDEN_SIGNATURE = 16'h0000,
   parameter int unsigned            EXPECTED_COUNT   = 0,
   parameter int unsigned            COUNT_W          = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  init,
   input  logic                  running,
   input  logic                  finish,
   input  logic                  mode,
   input  logic [NUM_CHAINS-1:0] scan_out,
`ifdef BIST_RSP_XMASK_EN
   input  logic [NUM_CHAINS-1:0] scan_mask,
`endif
   output logic [MISR_WIDTH-1:0] signature,
   output logic [COUNT_W-1:0]    compact_count,
   output logic                  done,
   output logic                  pass,
   output logic                  proto_err
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_COMPACT, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [MISR_WIDTH-1:0]   signature_q, signature_d;
   logic [COUNT_W-1:0]      count_q, count_d;
   logic                    done_q, done_d;
   logic                    pass_q, pass_d;
   logic                    proto_err_q, proto_err_d;

   logic [NUM_CHAINS-1:0]   scan_bits;
   logic [MISR_WIDTH-1:0]   misr_in;
   logic [MISR_WIDTH-1:0]   misr_next;
   logic [COUNT_W-1:0]      count_inc;
   logic                    golden_match;

`ifdef BIST_RSP_XMASK_EN
   assign scan_bits = scan_out & ~scan_mask;
`else
   assign scan_bits = scan_out;
`endif

   // Chain i drives MISR bit i; bits above NUM_CHAINS see zero.
   for (genvar gi = 0; gi < MISR_WIDTH; gi++) begin : g_misr_in
      if (gi < NUM_CHAINS) begin : g_chain
         assign misr_in[gi] = scan_bits[gi];
      end else begin : g_zero
         assign misr_in[gi] = 1'b0;
      end
   end

   assign misr_next = {signature_q[MISR_WIDTH-2:0], 1'b0}
                    ^ (signature_q[MISR_WIDTH-1] ? POLY : '0)
                    ^ misr_in;

   assign count_inc = (count_q == '1) ? count_q : count_q + COUNT_W'(1);

   // Compared against the registered values present when finish is sampled.
   assign golden_match = (signature_q == GOLDEN_SIGNATURE) &&
                         ((EXPECTED_COUNT == 0) || (count_q == COUNT_W'(EXPECTED_COUNT)));

   always_comb begin
      state_d     = state_q;
      signature_d = signature_q;
      count_d     = count_q;
      done_d      = done_q;
      pass_d      = pass_q;
      proto_err_d = proto_err_q;

      if (init) begin
         state_d     = S_ARMED;
         signature_d = SEED;
         count_d     = '0;
         done_d      = 1'b0;
         pass_d      = 1'b0;
         proto_err_d = 1'b0;
      end else begin
         case (state_q)
            S_ARMED: begin
               if (running) begin
                  state_d = S_COMPACT;
                  if (mode) begin
                     signature_d = misr_next;
                     count_d     = count_inc;
                  end
               end else if (finish) begin
                  state_d     = S_DONE;
                  done_d      = 1'b1;
                  pass_d      = 1'b0;
                  proto_err_d = 1'b1;
               end
            end
            S_COMPACT: begin
               if (finish) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  pass_d  = golden_match;
               end else if (running && mode) begin
                  signature_d = misr_next;
                  count_d     = count_inc;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         signature_q <= '0;
         count_q     <= '0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         signature_q <= signature_d;
         count_q     <= count_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign signature     = signature_q;
   assign compact_count = count_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign proto_err     = proto_err_q;

endmodule

// File: tb/tb_bist_response_analyzer.sv
// Directed, table-driven bench for bist_response_analyzer (W=4, 1 chain, POLY=3, GOLDEN=B, EXPECTED_COUNT=4).
module tb_bist_response_analyzer;

   localparam int W  = 4;
   localparam int NC = 1;
   localparam int CW = 3;

   logic          clock = 1'b0;
   logic          reset, init, running, finish, mode;
   logic [NC-1:0] scan_out;
   logic [W-1:0]  signature;
   logic [CW-1:0] compact_count;
   logic          done, pass, proto_err;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   bist_response_analyzer #(
      .MISR_WIDTH(W), .NUM_CHAINS(NC), .POLY(4'h3), .SEED(4'h0),
      .GOLDEN_SIGNATURE(4'hB), .EXPECTED_COUNT(4), .COUNT_W(CW)
   ) dut (
      .clock(clock), .reset(reset), .init(init), .running(running),
      .finish(finish), .mode(mode), .scan_out(scan_out),
`ifdef BIST_RSP_XMASK_EN
      .scan_mask(1'b0),
`endif
      .signature(signature), .compact_count(compact_count),
      .done(done), .pass(pass), .proto_err(proto_err)
   );

   typedef struct {
      logic       i, r, f, m, s;
      logic [3:0] sig;
      logic [2:0] cnt;
      logic       dn, ps, pe;
   } vec_t;

   vec_t vecs [23];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic i, input logic r, input logic f, input logic m, input logic s);
      init = i; running = r; finish = f; mode = m; scan_out = s;
      @(posedge clock);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [3:0] sig, input logic [2:0] cnt,
                            input logic dn, input logic ps, input logic pe);
      $display("[TB] %s sig=%h cnt=%0d done=%b pass=%b perr=%b", tag, signature, compact_count, done, pass, proto_err);
      chk({tag, ".sig"},  16'(signature),     16'(sig));
      chk({tag, ".cnt"},  16'(compact_count), 16'(cnt));
      chk({tag, ".done"}, 16'(done),          16'(dn));
      chk({tag, ".pass"}, 16'(pass),          16'(ps));
      chk({tag, ".perr"}, 16'(proto_err),     16'(pe));
   endtask

   function automatic vec_t mk(logic i, logic r, logic f, logic m, logic s,
                               logic [3:0] sig, logic [2:0] cnt, logic dn, logic ps, logic pe);
      vec_t v;
      v.i = i; v.r = r; v.f = f; v.m = m; v.s = s;
      v.sig = sig; v.cnt = cnt; v.dn = dn; v.ps = ps; v.pe = pe;
      return v;
   endfunction

   initial begin
      //              i  r  f  m  s   sig  cnt dn ps pe
      vecs[0]  = mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);  // nominal run
      vecs[1]  = mk(0, 1, 0, 1, 1, 4'h1, 1, 0, 0, 0);
      vecs[2]  = mk(0, 1, 0, 1, 0, 4'h2, 2, 0, 0, 0);
      vecs[3]  = mk(0, 1, 0, 1, 1, 4'h5, 3, 0, 0, 0);
      vecs[4]  = mk(0, 1, 0, 1, 1, 4'hB, 4, 0, 0, 0);
      vecs[5]  = mk(0, 1, 1, 1, 1, 4'hB, 4, 1, 1, 0);  // finish cycle not compacted
      vecs[6]  = mk(0, 0, 0, 0, 0, 4'hB, 4, 1, 1, 0);
      vecs[7]  = mk(0, 1, 0, 1, 1, 4'hB, 4, 1, 1, 0);  // DONE ignores running
      vecs[8]  = mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);  // mode=0 interleaved
      vecs[9]  = mk(0, 1, 0, 0, 1, 4'h0, 0, 0, 0, 0);
      vecs[10] = mk(0, 1, 0, 1, 1, 4'h1, 1, 0, 0, 0);
      vecs[11] = mk(0, 1, 0, 0, 1, 4'h1, 1, 0, 0, 0);
      vecs[12] = mk(0, 1, 0, 1, 0, 4'h2, 2, 0, 0, 0);
      vecs[13] = mk(0, 0, 0, 1, 1, 4'h2, 2, 0, 0, 0);
      vecs[14] = mk(0, 1, 0, 1, 1, 4'h5, 3, 0, 0, 0);
      vecs[15] = mk(0, 1, 0, 1, 1, 4'hB, 4, 0, 0, 0);
      vecs[16] = mk(0, 0, 1, 0, 0, 4'hB, 4, 1, 1, 0);
      vecs[17] = mk(1, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);  // protocol error
      vecs[18] = mk(0, 0, 1, 0, 0, 4'h0, 0, 1, 0, 1);
      vecs[19] = mk(1, 0, 1, 0, 0, 4'h0, 0, 0, 0, 0);  // init beats finish
      vecs[20] = mk(0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
      vecs[21] = mk(1, 1, 0, 1, 1, 4'h0, 0, 0, 0, 0);  // init beats running
      vecs[22] = mk(0, 1, 0, 1, 1, 4'h1, 1, 0, 0, 0);

      reset = 1'b1; init = 0; running = 0; finish = 0; mode = 0; scan_out = '0;
      repeat (3) @(posedge clock);
      #1;
      reset = 1'b0;
      step(0, 1, 1, 1, 1);  // IDLE ignores everything but init
      check_all("reset", 4'h0, 0, 0, 0, 0);

      for (int k = 0; k < 23; k++) begin
         step(vecs[k].i, vecs[k].r, vecs[k].f, vecs[k].m, vecs[k].s);
         check_all($sformatf("vec%0d", k), vecs[k].sig, vecs[k].cnt, vecs[k].dn, vecs[k].ps, vecs[k].pe);
      end

      // Count mismatch: fifth compaction
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1); step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 1);
      step(0, 1, 0, 1, 1); step(0, 1, 0, 1, 0);
      check_all("cnt5_pre", 4'h5, 5, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check_all("cnt5_fin", 4'h5, 5, 1, 0, 0);

      // Reset mid-run aborts; finish in IDLE gives no result
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1); step(0, 1, 0, 1, 0);
      check_all("rst_pre", 4'h2, 2, 0, 0, 0);
      reset = 1'b1;
      step(0, 1, 0, 1, 1);
      check_all("rst_mid", 4'h0, 0, 0, 0, 0);
      reset = 1'b0;
      step(0, 0, 1, 0, 0);
      step(0, 1, 0, 1, 1);
      check_all("rst_idle", 4'h0, 0, 0, 0, 0);

      // Init mid-run restarts, full rerun passes
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1); step(0, 1, 0, 1, 0);
      step(1, 1, 0, 1, 1);
      check_all("reinit", 4'h0, 0, 0, 0, 0);
      step(0, 1, 0, 1, 1); step(0, 1, 0, 1, 0); step(0, 1, 0, 1, 1); step(0, 1, 0, 1, 1);
      step(0, 0, 1, 0, 0);
      check_all("rerun", 4'hB, 4, 1, 1, 0);

      // Counter saturation at all-ones
      step(1, 0, 0, 0, 0);
      for (int k = 0; k < 9; k++) step(0, 1, 0, 1, 0);
      check_all("sat", 4'h0, 7, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      check_all("sat_fin", 4'h0, 7, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
